// File: rtl/div_unit_if.sv
// Operand and result handshake bundle for the iterative divider.
// A transfer happens on a rising clk edge where valid and ready are both high; a
// producer holds its payload stable from raising valid until that transfer edge.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             kill;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             busy;

  modport master (
    output in_valid, a, b, op, kill, out_ready,
    input  in_ready, out_valid, res, busy
  );

  modport slave (
    input  in_valid, a, b, op, kill, out_ready,
    output in_ready, out_valid, res, busy
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on magnitudes; signs are applied as the result is registered.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic       clk,
  input  logic       reset,
  div_unit_if.slave  io,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, div_q, res_q;
  logic             sel_rem_q, q_neg_q, r_neg_q;

  // Operand decode, evaluated on the raw inputs at accept time.
  logic             is_signed, a_neg, b_neg, div_zero, ovf, special, accept;
  logic [WIDTH-1:0] a_abs, b_abs, special_res;

  always_comb begin
    is_signed   = ~io.op[0];
    a_neg       = is_signed & io.a[WIDTH-1];
    b_neg       = is_signed & io.b[WIDTH-1];
    a_abs       = a_neg ? -io.a : io.a;
    b_abs       = b_neg ? -io.b : io.b;
    div_zero    = (io.b == '0);
    ovf         = is_signed & (io.a == {1'b1, {(WIDTH-1){1'b0}}}) & (io.b == '1);
    special     = div_zero | ovf;
    if (div_zero) special_res = io.op[1] ? io.a : '1;
    else          special_res = io.op[1] ? '0   : io.a;
    accept      = io.in_valid & (state_q == S_IDLE) & ~io.kill;
  end

  // Partial remainder is below the divisor, so the shifted value is below twice the
  // divisor and a WIDTH+1 bit difference has its top bit set exactly when negative.
  logic [WIDTH:0]   rem_sh, trial;
  logic             trial_ge;
  logic [WIDTH-1:0] rem_n, quo_n, q_fix, r_fix, fixed_res;

  always_comb begin
    rem_sh    = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_sh - {1'b0, div_q};
    trial_ge  = ~trial[WIDTH];
    rem_n     = trial_ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_n     = {quo_q[WIDTH-2:0], trial_ge};
    q_fix     = q_neg_q ? -quo_n : quo_n;
    r_fix     = r_neg_q ? -rem_n : rem_n;
    fixed_res = sel_rem_q ? r_fix : q_fix;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC: begin
        if (io.kill)                     state_d = S_IDLE;
        else if (cnt_q == CNT_W'(1))     state_d = S_DONE;
      end
      S_DONE: begin
        if (io.kill)                     state_d = S_IDLE;
        else if (io.out_ready)           state_d = S_IDLE;
      end
      default:                           state_d = S_IDLE;
    endcase
  end

  always_comb begin
    io.in_ready  = (state_q == S_IDLE);
    io.out_valid = (state_q == S_DONE);
    io.busy      = (state_q != S_IDLE);
    io.res       = res_q;
    state_dbg    = state_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      res_q     <= '0;
      sel_rem_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
    end else if (accept) begin
      sel_rem_q <= io.op[1];
      q_neg_q   <= a_neg ^ b_neg;
      r_neg_q   <= a_neg;
      div_q     <= b_abs;
      rem_q     <= '0;
      quo_q     <= a_abs;
      cnt_q     <= CNT_W'(WIDTH);
      if (special) res_q <= special_res;
    end else if (state_q == S_CALC && !io.kill) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) res_q <= fixed_res;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Randomised and directed checks of div_unit against a plain-arithmetic RV32M model.
module tb_div_unit;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;
  int         total = 0;
  int         bad = 0;
  logic [W-1:0] exp_q[$];

  div_unit_if #(.WIDTH(W)) dif ();

  div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .io        (dif.slave),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V division semantics straight from arithmetic operators.
  function automatic logic [W-1:0] ref_div(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int signed sx, sy;
    logic      ovf;
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      2'd0:    if (y == 0) return 32'hFFFF_FFFF; else if (ovf) return x; else return sx / sy;
      2'd1:    if (y == 0) return 32'hFFFF_FFFF; else return x / y;
      2'd2:    if (y == 0) return x; else if (ovf) return 32'h0; else return sx % sy;
      default: if (y == 0) return x; else return x % y;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    return (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  task automatic accept_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    dif.in_valid = 1'b1; dif.a = x; dif.b = y; dif.op = o;
    @(negedge clk);
    dif.in_valid = 1'b0; dif.a = $urandom; dif.b = $urandom; dif.op = 2'($urandom_range(0, 3));
  endtask

  // Full transaction: accept, wait bounded for out_valid, check latency/result/handoff.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string name);
    int           lat, want_lat;
    logic [W-1:0] want;
    exp_q.push_back(ref_div(o, x, y));
    want_lat = is_special(o, x, y) ? 1 : W + 1;
    @(negedge clk);
    total++;
    if (dif.in_ready !== 1'b1) begin
      bad++; $display("FAIL %s_ready got=%0b want=1", name, dif.in_ready);
    end
    dif.in_valid = 1'b1; dif.a = x; dif.b = y; dif.op = o;
    @(negedge clk);
    dif.in_valid = 1'b0; dif.a = $urandom; dif.b = $urandom; dif.op = 2'($urandom_range(0, 3));
    lat = 1;
    while (dif.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk); lat++;
    end
    total++;
    if (lat != want_lat) begin
      bad++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, want_lat);
    end
    want = exp_q.pop_front();
    total++;
    if (dif.res !== want) begin
      bad++; $display("FAIL %s_res op=%0d a=%h b=%h got=%h want=%h", name, o, x, y, dif.res, want);
    end
    dif.out_ready = 1'b1;
    @(negedge clk);
    dif.out_ready = 1'b0;
    total++;
    if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0 || dif.busy !== 1'b0) begin
      bad++; $display("FAIL %s_handoff in_ready=%0b out_valid=%0b busy=%0b want 1/0/0",
                      name, dif.in_ready, dif.out_valid, dif.busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dif.in_valid = 1'b0; dif.a = '0; dif.b = '0; dif.op = '0; dif.kill = 1'b0; dif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0 || dif.busy !== 1'b0 ||
        dif.res !== '0 || state_dbg !== 2'd0) begin
      bad++; $display("FAIL reset_outputs in_ready=%0b out_valid=%0b busy=%0b res=%h state=%0d want 1/0/0/0/0",
                      dif.in_ready, dif.out_valid, dif.busy, dif.res, state_dbg);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_op(2'd1, 32'd100, 32'd7, "divu_100_7");
    run_op(2'd3, 32'd100, 32'd7, "remu_100_7");
    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run_op(2'd0, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE, "rem_7_m2");
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "divu_big");
    run_op(2'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, "remu_big");
  endtask

  task automatic test_special();
    run_op(2'd1, 32'h1234, 32'd0, "divu_by_zero");
    run_op(2'd2, 32'hFFFF_FFFB, 32'd0, "rem_by_zero");
    run_op(2'd0, 32'hFFFF_FFFB, 32'd0, "div_by_zero");
    run_op(2'd3, 32'hDEAD_BEEF, 32'd0, "remu_by_zero");
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
    run_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, "divu_no_overflow");
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic [1:0]   o;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 7))
        0:       y = '0;
        1:       begin y = 32'hFFFF_FFFF; x = 32'h8000_0000; end
        2:       y = $urandom_range(1, 15);
        3:       y = -($urandom_range(1, 15));
        4:       y = x + 1;
        default: y = $urandom;
      endcase
      if (y == '0 && $urandom_range(0, 3) == 0) x = '0;
      run_op(o, x, y, "random");
    end
  endtask

  task automatic test_backpressure();
    int           lat;
    logic [W-1:0] want;
    want = ref_div(2'd0, 32'hFFFF_FC18, 32'd10);
    accept_op(2'd0, 32'hFFFF_FC18, 32'd10);
    lat = 1;
    while (dif.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk); lat++;
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (dif.out_valid !== 1'b1 || dif.res !== want || dif.in_ready !== 1'b0) begin
        bad++; $display("FAIL backpressure_hold cyc=%0d out_valid=%0b res=%h in_ready=%0b want 1/%h/0",
                        i, dif.out_valid, dif.res, dif.in_ready, want);
      end
      @(negedge clk);
    end
    dif.out_ready = 1'b1;
    @(negedge clk);
    dif.out_ready = 1'b0;
    total++;
    if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0) begin
      bad++; $display("FAIL backpressure_release in_ready=%0b out_valid=%0b want 1/0", dif.in_ready, dif.out_valid);
    end
  endtask

  task automatic test_in_valid_during_calc();
    int           lat;
    logic [W-1:0] want;
    want = ref_div(2'd2, 32'd1_000_003, 32'hFFFF_FFF9);
    accept_op(2'd2, 32'd1_000_003, 32'hFFFF_FFF9);
    lat = 1;
    repeat (4) begin @(negedge clk); lat++; end
    dif.in_valid = 1'b1; dif.a = 32'd50; dif.b = 32'd5; dif.op = 2'd1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (dif.in_ready !== 1'b0) begin
        bad++; $display("FAIL calc_in_ready cyc=%0d got=%0b want=0", lat, dif.in_ready);
      end
      @(negedge clk); lat++;
    end
    dif.in_valid = 1'b0;
    while (dif.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk); lat++;
    end
    total++;
    if (lat != W + 1 || dif.res !== want) begin
      bad++; $display("FAIL calc_ignore_res lat=%0d res=%h want lat=%0d res=%h", lat, dif.res, W + 1, want);
    end
    dif.out_ready = 1'b1;
    @(negedge clk);
    dif.out_ready = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (dif.busy !== 1'b0 || dif.out_valid !== 1'b0) begin
      bad++; $display("FAIL calc_ignore_idle busy=%0b out_valid=%0b want 0/0", dif.busy, dif.out_valid);
    end
  endtask

  task automatic test_kill();
    int lat;
    bit seen;
    accept_op(2'd1, 32'hCAFE_F00D, 32'd3);
    lat = 1;
    while (lat < 15) begin @(negedge clk); lat++; end
    dif.kill = 1'b1;
    @(negedge clk);
    dif.kill = 1'b0;
    total++;
    if (dif.in_ready !== 1'b1 || dif.busy !== 1'b0 || state_dbg !== 2'd0) begin
      bad++; $display("FAIL kill_calc in_ready=%0b busy=%0b state=%0d want 1/0/0", dif.in_ready, dif.busy, state_dbg);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (dif.out_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL kill_no_output got out_valid=1 want never");
    end
    // kill beats in_valid while idle
    @(negedge clk);
    dif.in_valid = 1'b1; dif.kill = 1'b1; dif.a = 32'd9; dif.b = 32'd3; dif.op = 2'd1;
    @(negedge clk);
    dif.in_valid = 1'b0; dif.kill = 1'b0;
    total++;
    if (dif.busy !== 1'b0 || dif.in_ready !== 1'b1) begin
      bad++; $display("FAIL kill_idle busy=%0b in_ready=%0b want 0/1", dif.busy, dif.in_ready);
    end
    accept_op(2'd1, 32'd9, 32'd0);
    dif.kill = 1'b1;
    @(negedge clk);
    dif.kill = 1'b0;
    total++;
    if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1) begin
      bad++; $display("FAIL kill_done out_valid=%0b in_ready=%0b want 0/1", dif.out_valid, dif.in_ready);
    end
  endtask

  task automatic test_reset_mid_calc();
    run_op(2'd1, 32'd77, 32'd0, "pre_reset");
    accept_op(2'd1, 32'h7777_7777, 32'd5);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0 || dif.busy !== 1'b0 || dif.res !== '0) begin
      bad++; $display("FAIL reset_mid_calc in_ready=%0b out_valid=%0b busy=%0b res=%h want 1/0/0/0",
                      dif.in_ready, dif.out_valid, dif.busy, dif.res);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op(2'd1, 32'hFFFF_FFFF, 32'd1, "after_reset_divu");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_special();
    test_backpressure();
    test_in_valid_during_calc();
    test_kill();
    test_reset_mid_calc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
